// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative MDU.
// Owns the EX/MEM pipeline register; stalls upstream while the MDU runs.
module ex_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  syncClr,
  input  logic [3:0]            aluOperation,
  input  logic [DATA_WIDTH-1:0] readData1,
  input  logic [DATA_WIDTH-1:0] readData2,
  input  logic [DATA_WIDTH-1:0] sigExt,
  input  logic [4:0]            rs,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic [4:0]            sa,
  input  logic                  aluSrc,
  input  logic                  aluShiftImm,
  input  logic                  regDst,
  input  logic                  loadImm,
  input  logic [3:0]            memWrite,
  input  logic                  memToReg,
  input  logic [1:0]            memReadWidth,
  input  logic                  regWrite,
  input  logic                  exMemRegWriteIn,
  input  logic                  memWbRegWrite,
  input  logic [4:0]            exMemRdIn,
  input  logic [4:0]            memWbRd,
  input  logic [DATA_WIDTH-1:0] memWbData,
  output logic [DATA_WIDTH-1:0] aluResultOut,
  output logic [DATA_WIDTH-1:0] writeDataOut,
  output logic [4:0]            writeRegOut,
  output logic [3:0]            memWriteOut,
  output logic                  memToRegOut,
  output logic [1:0]            memReadWidthOut,
  output logic                  regWriteOut,
  output logic                  stallOut
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mduState_t;

  mduState_t state, stateNext;

  logic [DATA_WIDTH-1:0] fwdA, fwdB, opB;
  logic [DATA_WIDTH-1:0] aluResult, mduResult;
  logic [DATA_WIDTH-1:0] acc, quo, dvs;
  logic [DATA_WIDTH:0]   shifted, diff;
  logic [4:0]            shamt, writeReg;
  logic [CW-1:0]         count;
  logic [3:0]            mduOpReg;
  logic                  mduOp, loadEx, isMul;
  logic                  unusedIn;

  // exported EX/MEM copies are not needed: the internal register is the source
  assign unusedIn = ^{exMemRegWriteIn, exMemRdIn};

  // operand forwarding, EX/MEM has priority over MEM/WB
  always_comb begin
    fwdA = readData1;
    fwdB = readData2;
    if (regWriteOut && writeRegOut != 5'd0 && writeRegOut == rs)
      fwdA = aluResultOut;
    else if (memWbRegWrite && memWbRd != 5'd0 && memWbRd == rs)
      fwdA = memWbData;
    if (regWriteOut && writeRegOut != 5'd0 && writeRegOut == rt)
      fwdB = aluResultOut;
    else if (memWbRegWrite && memWbRd != 5'd0 && memWbRd == rt)
      fwdB = memWbData;
  end

  assign opB      = aluSrc ? sigExt : fwdB;
  assign shamt    = aluShiftImm ? sa : fwdA[4:0];
  assign writeReg = regDst ? rd : rt;
  assign mduOp    = !loadImm && (aluOperation == 4'd12 ||
                    aluOperation == 4'd13 || aluOperation == 4'd14);
  assign stallOut = (state == IDLE && mduOp) || state == BUSY;
  assign loadEx   = state == DONE || (state == IDLE && !mduOp);
  assign isMul    = mduOpReg == 4'd12;

  // single-cycle ALU
  always_comb begin
    aluResult = '0;
    if (loadImm) begin
      aluResult = {sigExt[15:0], {(DATA_WIDTH-16){1'b0}}};
    end else begin
      case (aluOperation)
        4'd0:  aluResult = fwdA + opB;
        4'd1:  aluResult = fwdA - opB;
        4'd2:  aluResult = fwdA & opB;
        4'd3:  aluResult = fwdA | opB;
        4'd4:  aluResult = fwdA ^ opB;
        4'd5:  aluResult = ~(fwdA | opB);
        4'd6:  aluResult = {{(DATA_WIDTH-1){1'b0}},
                            $signed(fwdA) < $signed(opB)};
        4'd7:  aluResult = {{(DATA_WIDTH-1){1'b0}}, fwdA < opB};
        4'd8:  aluResult = fwdB << shamt;
        4'd9:  aluResult = fwdB >> shamt;
        4'd10: aluResult = $unsigned($signed(fwdB) >>> shamt);
        default: aluResult = '0;
      endcase
    end
  end

  // restoring-divide step and MDU result select
  always_comb begin
    shifted   = {acc, quo[DATA_WIDTH-1]};
    diff      = shifted - {1'b0, dvs};
    mduResult = acc;
    if (mduOpReg == 4'd13)
      mduResult = quo;
  end

  // MDU next state; a flush always returns to IDLE
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (mduOp) stateNext = BUSY;
      BUSY:    if (count == CW'(DATA_WIDTH-1)) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (syncClr)
      stateNext = IDLE;
  end

  // MDU state register
  always_ff @(negedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= stateNext;
  end

  // MDU datapath: operand latch at start, then one step per edge
  always_ff @(negedge clock) begin
    if (reset) begin
      acc      <= '0;
      quo      <= '0;
      dvs      <= '0;
      count    <= '0;
      mduOpReg <= '0;
    end else if (state == IDLE && mduOp) begin
      acc      <= '0;
      count    <= '0;
      mduOpReg <= aluOperation;
      if (aluOperation == 4'd12) begin
        quo <= opB;
        dvs <= fwdA;
      end else begin
        quo <= fwdA;
        dvs <= opB;
      end
    end else if (state == BUSY) begin
      count <= count + 1'b1;
      if (isMul) begin
        if (quo[0])
          acc <= acc + dvs;
        dvs <= dvs << 1;
        quo <= quo >> 1;
      end else if (!diff[DATA_WIDTH]) begin
        acc <= diff[DATA_WIDTH-1:0];
        quo <= {quo[DATA_WIDTH-2:0], 1'b1};
      end else begin
        acc <= shifted[DATA_WIDTH-1:0];
        quo <= {quo[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  // EX/MEM register: result or bubble
  always_ff @(negedge clock) begin
    if (reset || syncClr || !loadEx) begin
      aluResultOut    <= '0;
      writeDataOut    <= '0;
      writeRegOut     <= '0;
      memWriteOut     <= '0;
      memToRegOut     <= 1'b0;
      memReadWidthOut <= '0;
      regWriteOut     <= 1'b0;
    end else begin
      aluResultOut    <= (state == DONE) ? mduResult : aluResult;
      writeDataOut    <= fwdB;
      writeRegOut     <= writeReg;
      memWriteOut     <= memWrite;
      memToRegOut     <= memToReg;
      memReadWidthOut <= memReadWidth;
      regWriteOut     <= regWrite;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors queue expectations,
// a posedge monitor pops and compares them against the DUT.
module tb_ex_stage;

  logic        clock, reset, syncClr;
  logic [3:0]  aluOperation;
  logic [31:0] readData1, readData2, sigExt;
  logic [4:0]  rs, rt, rd, sa;
  logic        aluSrc, aluShiftImm, regDst, loadImm;
  logic [3:0]  memWrite;
  logic        memToReg;
  logic [1:0]  memReadWidth;
  logic        regWrite;
  logic        exMemRegWriteIn, memWbRegWrite;
  logic [4:0]  exMemRdIn, memWbRd;
  logic [31:0] memWbData;
  logic [31:0] aluResultOut, writeDataOut;
  logic [4:0]  writeRegOut;
  logic [3:0]  memWriteOut;
  logic        memToRegOut;
  logic [1:0]  memReadWidthOut;
  logic        regWriteOut, stallOut;

  assign exMemRegWriteIn = regWriteOut;
  assign exMemRdIn       = writeRegOut;

  ex_stage dut (
    .clock(clock), .reset(reset), .syncClr(syncClr),
    .aluOperation(aluOperation),
    .readData1(readData1), .readData2(readData2),
    .sigExt(sigExt), .rs(rs), .rt(rt), .rd(rd), .sa(sa),
    .aluSrc(aluSrc), .aluShiftImm(aluShiftImm),
    .regDst(regDst), .loadImm(loadImm),
    .memWrite(memWrite), .memToReg(memToReg),
    .memReadWidth(memReadWidth), .regWrite(regWrite),
    .exMemRegWriteIn(exMemRegWriteIn),
    .memWbRegWrite(memWbRegWrite),
    .exMemRdIn(exMemRdIn), .memWbRd(memWbRd),
    .memWbData(memWbData),
    .aluResultOut(aluResultOut), .writeDataOut(writeDataOut),
    .writeRegOut(writeRegOut), .memWriteOut(memWriteOut),
    .memToRegOut(memToRegOut),
    .memReadWidthOut(memReadWidthOut),
    .regWriteOut(regWriteOut), .stallOut(stallOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] res;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic [3:0]  mw;
    logic        mtr;
    logic [1:0]  mrw;
    logic        rw;
  } exp_t;

  typedef struct {
    string sname;
    logic  expStall;
    exp_t  o;
  } chk_t;

  chk_t q[$];
  chk_t mon;
  exp_t cur;
  int   nVec = 0;
  int   nBad = 0;

  function automatic exp_t mk(string n, logic [31:0] res,
                              logic [31:0] wd, logic [4:0] wr,
                              logic rw);
    exp_t e;
    e.name = n; e.valid = 1'b1;
    e.res = res; e.wd = wd; e.wr = wr;
    e.mw = '0; e.mtr = 1'b0; e.mrw = '0; e.rw = rw;
    return e;
  endfunction

  function automatic exp_t bub(string n);
    return mk(n, 32'h0, 32'h0, 5'd0, 1'b0);
  endfunction

  // monitor: compare the queued expectation at mid-cycle
  always @(posedge clock) begin
    if (q.size() > 0) begin
      mon = q.pop_front();
      if (mon.expStall !== 1'bx) begin
        nVec++;
        if (stallOut !== mon.expStall) begin
          nBad++;
          $display("FAIL %s stall got %0b want %0b",
                   mon.sname, stallOut, mon.expStall);
        end
      end
      if (mon.o.valid) begin
        nVec++;
        if ({aluResultOut, writeDataOut, writeRegOut, memWriteOut,
             memToRegOut, memReadWidthOut, regWriteOut} !==
            {mon.o.res, mon.o.wd, mon.o.wr, mon.o.mw,
             mon.o.mtr, mon.o.mrw, mon.o.rw}) begin
          nBad++;
          $display({"FAIL %s exmem got res=%h wd=%h wr=%0d mw=%h",
                    " mtr=%0b mrw=%0d rw=%0b want res=%h wd=%h",
                    " wr=%0d mw=%h mtr=%0b mrw=%0d rw=%0b"},
                   mon.o.name, aluResultOut, writeDataOut,
                   writeRegOut, memWriteOut, memToRegOut,
                   memReadWidthOut, regWriteOut, mon.o.res,
                   mon.o.wd, mon.o.wr, mon.o.mw, mon.o.mtr,
                   mon.o.mrw, mon.o.rw);
        end
      end
    end
  end

  task automatic clearIn();
    syncClr = 0; aluOperation = 0;
    readData1 = 0; readData2 = 0; sigExt = 0;
    rs = 0; rt = 0; rd = 0; sa = 0;
    aluSrc = 0; aluShiftImm = 0; regDst = 0; loadImm = 0;
    memWrite = 0; memToReg = 0; memReadWidth = 0; regWrite = 0;
    memWbRegWrite = 0; memWbRd = 0; memWbData = 0;
  endtask

  task automatic alu(input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rsI,
                     input logic [4:0] rtI, input logic [4:0] rdI,
                     input logic rw);
    clearIn();
    aluOperation = op; readData1 = a; readData2 = b;
    rs = rsI; rt = rtI; rd = rdI; regDst = 1; regWrite = rw;
  endtask

  // queue this cycle's expectation, then advance one edge
  task automatic tick(input string n, input logic st);
    chk_t c;
    c.sname = n; c.expStall = st; c.o = cur;
    q.push_back(c);
    @(negedge clock);
    #1;
  endtask

  // kind: 0 complete, 1 flush at BUSY cycle 'at',
  //       2 reset at BUSY cycle 'at', 3 flush in DONE
  task automatic mdu(input string n, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input int kind,
                     input int at);
    alu(op, a, b, 6, 9, 11, 1);
    tick(n, 1);
    cur = bub(n);
    for (int i = 1; i <= 32; i++) begin
      if ((kind == 1 || kind == 2) && i == at) begin
        if (kind == 1) syncClr = 1;
        else reset = 1;
        tick(n, 1);
        cur = bub(n);
        reset = 0;
        clearIn();
        tick({n, "_post"}, 0);
        cur = bub({n, "_post"});
        return;
      end
      readData1 = 32'hDEAD0000 | 32'(i);
      readData2 = 32'h0BAD0000 | 32'(i);
      tick(n, 1);
    end
    readData1 = a; readData2 = b;
    if (kind == 3) begin
      syncClr = 1;
      tick(n, 0);
      cur = bub(n);
      clearIn();
      return;
    end
    tick(n, 0);
    cur = mk(n, res, b, 11, 1);
  endtask

  initial begin
    cur = bub("none");
    cur.valid = 1'b0;
    reset = 1;
    alu(0, 5, 7, 1, 2, 3, 1);
    tick("rst", 1'bx);
    cur = bub("rst");
    tick("rst2", 0);
    cur = bub("rst2");
    reset = 0;

    alu(0, 5, 7, 1, 2, 3, 1);
    tick("add", 0);
    cur = mk("add", 12, 7, 3, 1);

    alu(0, 32'hAA, 0, 1, 2, 4, 1);
    tick("fwdset", 0);
    cur = mk("fwdset", 32'hAA, 0, 4, 1);

    alu(3, 32'h11, 1, 4, 0, 0, 1);
    memWbRegWrite = 1; memWbRd = 4; memWbData = 32'hBB;
    tick("fwdex", 0);
    cur = mk("fwdex", 32'hAB, 1, 0, 1);

    alu(0, 32'h100, 32'h55, 0, 4, 5, 0);
    memWbRegWrite = 1; memWbRd = 4; memWbData = 32'hBB;
    memWrite = 4'hF; memToReg = 1; memReadWidth = 2;
    tick("fwdz", 0);
    cur = mk("fwdz", 32'h1BB, 32'hBB, 5, 0);
    cur.mw = 4'hF; cur.mtr = 1; cur.mrw = 2;

    alu(1, 3, 5, 1, 2, 2, 1);
    tick("sub", 0);
    cur = mk("sub", 32'hFFFFFFFE, 5, 2, 1);

    alu(10, 0, 32'h80000000, 6, 7, 8, 1);
    aluShiftImm = 1; sa = 4;
    tick("sra", 0);
    cur = mk("sra", 32'hF8000000, 32'h80000000, 8, 1);

    alu(9, 8, 32'h80000000, 6, 7, 8, 1);
    sa = 4;
    tick("srl", 0);
    cur = mk("srl", 32'h00800000, 32'h80000000, 8, 1);

    alu(12, 0, 0, 6, 7, 0, 1);
    regDst = 0; loadImm = 1; sigExt = 32'h1234;
    tick("lui", 0);
    cur = mk("lui", 32'h12340000, 0, 7, 1);

    alu(6, 32'hFFFFFFFF, 9, 6, 9, 10, 1);
    aluSrc = 1; sigExt = 1;
    tick("slt", 0);
    cur = mk("slt", 1, 9, 10, 1);

    alu(7, 32'hFFFFFFFF, 9, 6, 9, 10, 1);
    aluSrc = 1; sigExt = 1;
    tick("sltu", 0);
    cur = mk("sltu", 0, 9, 10, 1);

    alu(6, 5, 32'hFFFFFFFD, 6, 9, 10, 1);
    tick("slt2", 0);
    cur = mk("slt2", 0, 32'hFFFFFFFD, 10, 1);

    alu(7, 5, 32'hFFFFFFFD, 6, 9, 10, 1);
    tick("sltu2", 0);
    cur = mk("sltu2", 1, 32'hFFFFFFFD, 10, 1);

    alu(8, 0, 3, 6, 9, 10, 1);
    aluShiftImm = 1; sa = 31;
    tick("sll", 0);
    cur = mk("sll", 32'h80000000, 3, 10, 1);

    alu(5, 32'h0F0F0F0F, 32'h00FF00FF, 6, 9, 10, 1);
    tick("nor", 0);
    cur = mk("nor", 32'hF000F000, 32'h00FF00FF, 10, 1);

    alu(4, 32'h0F0F0F0F, 32'h00FF00FF, 6, 9, 10, 1);
    tick("xor", 0);
    cur = mk("xor", 32'h0FF00FF0, 32'h00FF00FF, 10, 1);

    alu(2, 32'h0F0F0F0F, 32'h00FF00FF, 6, 9, 10, 1);
    tick("and", 0);
    cur = mk("and", 32'h000F000F, 32'h00FF00FF, 10, 1);

    alu(3, 32'h0F0F0F0F, 32'h00FF00FF, 6, 9, 10, 1);
    tick("or", 0);
    cur = mk("or", 32'h0FFF0FFF, 32'h00FF00FF, 10, 1);

    alu(11, 32'h0F0F0F0F, 32'h00FF00FF, 6, 9, 10, 1);
    tick("op11", 0);
    cur = mk("op11", 0, 32'h00FF00FF, 10, 1);

    alu(0, 1, 1, 6, 9, 10, 1);
    syncClr = 1;
    tick("flush", 0);
    cur = bub("flush");

    mdu("mul", 12, 32'hFFFFFFFF, 3, 32'hFFFFFFFD, 0, 0);

    alu(0, 0, 5, 11, 0, 12, 0);
    tick("fwdmul", 0);
    cur = mk("fwdmul", 2, 5, 12, 0);

    mdu("divu", 13, 100, 7, 14, 0, 0);
    mdu("remu", 14, 100, 7, 2, 0, 0);
    mdu("div0", 13, 5, 0, 32'hFFFFFFFF, 0, 0);
    mdu("rem0", 14, 9, 0, 9, 0, 0);
    mdu("clr10", 12, 7, 9, 0, 1, 10);
    mdu("rst5", 13, 100, 7, 0, 2, 5);
    mdu("clrdone", 13, 100, 7, 0, 3, 0);

    alu(0, 1, 1, 6, 9, 13, 1);
    tick("post", 0);
    cur = mk("post", 2, 1, 13, 1);
    clearIn();
    tick("end", 0);

    @(posedge clock);
    #1;
    if (q.size() != 0) begin
      nVec++;
      nBad++;
      $display("FAIL drain queue got %0d left want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nVec, nBad);
    $finish;
  end

endmodule
